// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4-channel TDM receive path: channel count,
// slot counter width and the alignment state encoding.
package tdm_demux4_pkg;

    localparam int TDM_NUM_CH = 4;
    localparam int TDM_SLOT_W = 2;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } tdm_state_e;

    // Frame counter width; a one-frame word still needs a 1-bit counter.
    function automatic int frame_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux4_chan_shift.sv
// One channel word accumulator: MSB-first shift register with a clear that
// can restart the word on the same cycle a fresh first bit is loaded.
module tdm_chan_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value: restart, clear, shift or hold.
    always_comb begin
        data_d = data_q;
        if (clr_i && en_i) begin
            data_d = WIDTH'(bit_i);
        end else if (clr_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = (data_q << 1) | WIDTH'(bit_i);
        end else begin
            data_d = data_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/tdm_demux4.sv
// TDM receive de-interleaver: aligns to the word-start sync marker, rebuilds
// four WIDTH-bit channel words and presents them through a valid/ready register.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sync,
    input  logic                  in_bit,
    output logic [4*WIDTH-1:0]    out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sync_err,
    output logic                  overrun
);

    localparam int FW = frame_w(WIDTH);
    localparam logic [FW-1:0] FRAME_LAST = FW'(WIDTH - 1);

    tdm_state_e               state_q, state_d;
    logic [TDM_SLOT_W-1:0]    slot_q, slot_d;
    logic [FW-1:0]            frame_q, frame_d;
    logic [4*WIDTH-1:0]       out_data_q;
    logic                     out_valid_q, sync_err_q, overrun_q;

    logic                     word_start_s, start_s, misplaced_s, missing_s;
    logic                     advance_s, complete_s, clr_s;
    logic [TDM_NUM_CH-1:0]    en_s;
    logic [WIDTH-1:0]         ch_q [TDM_NUM_CH];
    logic [WIDTH-1:0]         ch3_next_s;

    // Classify the accepted bit against the current alignment.
    always_comb begin
        start_s      = 1'b0;
        misplaced_s  = 1'b0;
        missing_s    = 1'b0;
        advance_s    = 1'b0;
        complete_s   = 1'b0;
        word_start_s = (slot_q == TDM_SLOT_W'(0)) && (frame_q == FW'(0));
        if (in_valid) begin
            if (state_q == ST_HUNT) begin
                start_s = in_sync;
            end else if (in_sync && !word_start_s) begin
                misplaced_s = 1'b1;
                start_s     = 1'b1;
            end else if (!in_sync && word_start_s) begin
                missing_s = 1'b1;
            end else begin
                advance_s  = 1'b1;
                complete_s = (slot_q == TDM_SLOT_W'(3)) && (frame_q == FRAME_LAST);
            end
        end else begin
            start_s = 1'b0;
        end
    end

    // Counter and state next values.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        frame_d = frame_q;
        if (start_s) begin
            state_d = ST_RUN;
            slot_d  = TDM_SLOT_W'(1);
            frame_d = FW'(0);
        end else if (missing_s) begin
            state_d = ST_HUNT;
            slot_d  = TDM_SLOT_W'(0);
            frame_d = FW'(0);
        end else if (advance_s) begin
            slot_d = slot_q + TDM_SLOT_W'(1);
            if (slot_q == TDM_SLOT_W'(3)) begin
                frame_d = (frame_q == FRAME_LAST) ? FW'(0) : frame_q + FW'(1);
            end else begin
                frame_d = frame_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Channel enables: a restart always lands in ch0.
    always_comb begin
        clr_s = start_s | missing_s;
        for (int i = 0; i < TDM_NUM_CH; i++) begin
            en_s[i] = (advance_s && (slot_q == TDM_SLOT_W'(i))) || (start_s && (i == 0));
        end
    end

    for (genvar g = 0; g < TDM_NUM_CH; g++) begin : g_chan
        tdm_chan_shift #(.WIDTH(WIDTH)) u_shift (
            .clk    (clk),
            .rst    (rst),
            .en_i   (en_s[g]),
            .clr_i  (clr_s),
            .bit_i  (in_bit),
            .data_o (ch_q[g])
        );
    end

    // The completing bit is ch3's LSB; fold it in so the set loads this edge.
    assign ch3_next_s = (ch_q[3] << 1) | WIDTH'(in_bit);

    // FSM, counters, output register and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            slot_q      <= '0;
            frame_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            frame_q    <= frame_d;
            sync_err_q <= misplaced_s | missing_s;
            if (complete_s) begin
                out_data_q  <= {ch3_next_s, ch_q[2], ch_q[1], ch_q[0]};
                out_valid_q <= 1'b1;
                if (out_valid_q && !out_ready) begin
                    overrun_q <= 1'b1;
                end else begin
                    overrun_q <= overrun_q;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_q;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (WIDTH=8): directed word-set table,
// alignment corner sequences and randomized traffic against a bit-list model.
module tb_tdm_demux4;

    localparam int W = 8;
    localparam int NB = 4 * W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_sync;
    logic          in_bit;
    logic [NB-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          sync_err;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    // Reference model: list of bits accepted since the current word started.
    bit          m_hunt = 1'b1;
    bit          m_q[$];
    logic        m_valid = 1'b0;
    logic [NB-1:0] m_data = '0;
    logic        m_err = 1'b0;
    logic        m_ovr = 1'b0;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .in_bit    (in_bit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sync_err  (sync_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  c0, c1, c2, c3;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic s, input logic b,
                              input logic rdy);
        logic done;
        logic [NB-1:0] w;
        done = 1'b0;
        w = '0;
        if (r) begin
            m_hunt = 1'b1; m_q.delete(); m_valid = 1'b0; m_data = '0;
            m_err = 1'b0; m_ovr = 1'b0;
            return;
        end
        m_err = 1'b0;
        if (v) begin
            if (m_hunt) begin
                if (s) begin
                    m_hunt = 1'b0; m_q.delete(); m_q.push_back(b);
                end
            end else if (s && m_q.size() != 0) begin
                m_err = 1'b1; m_q.delete(); m_q.push_back(b);
            end else if (!s && m_q.size() == 0) begin
                m_err = 1'b1; m_hunt = 1'b1;
            end else begin
                m_q.push_back(b);
                if (m_q.size() == NB) begin
                    done = 1'b1;
                    for (int c = 0; c < 4; c++)
                        for (int k = 0; k < W; k++)
                            w[c*W + (W-1-k)] = m_q[k*4 + c];
                    m_q.delete();
                end
            end
        end
        if (done) begin
            if (m_valid && !rdy) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = w;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic b,
                        input logic rdy);
        rst = r; in_valid = v; in_sync = s; in_bit = b; out_ready = rdy;
        @(posedge clk);
        model_edge(r, v, s, b, rdy);
        #1;
        chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("model_sync_err", {31'd0, sync_err}, {31'd0, m_err});
        chk("model_overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("model_out_data", out_data, m_data);
    endtask

    // Bits j0..j1-1 of the set {c3,c2,c1,c0}; sync marks bit sync_j.
    task automatic send_range(input logic [31:0] set, input int j0, input int j1,
                              input int sync_j, input logic rdy, input bit gap);
        for (int j = j0; j < j1; j++) begin
            if (gap) step(1'b0, 1'b0, 1'b0, 1'b0, rdy);
            step(1'b0, 1'b1, (j == sync_j), set[(j % 4) * W + (W - 1 - j / 4)], rdy);
        end
    endtask

    vec_t vecs[5];
    logic [31:0] sa, sb, sc;

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 32'h00FF3CA5};
        vecs[1] = '{8'h01, 8'h80, 8'h55, 8'hAA, 32'hAA558001};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
        vecs[3] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h78563412};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);

        // Table: contiguous then gapped streams, out_ready held high.
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 5; i++) begin
                sa = {vecs[i].c3, vecs[i].c2, vecs[i].c1, vecs[i].c0};
                send_range(sa, 0, NB, 0, 1'b1, (g == 1));
                chk("table_valid", {31'd0, out_valid}, 32'd1);
                chk("table_data", out_data, vecs[i].exp);
                chk("table_no_err", {31'd0, sync_err}, 32'd0);
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                chk("table_valid_drop", {31'd0, out_valid}, 32'd0);
            end
        end

        // Two sets with out_ready low: second overwrites and flags overrun.
        sa = 32'h00FF3CA5;
        sb = 32'h78563412;
        send_range(sa, 0, NB, 0, 1'b0, 1'b0);
        chk("ovr_first_clear", {31'd0, overrun}, 32'd0);
        send_range(sb, 0, NB, 0, 1'b0, 1'b0);
        chk("ovr_valid", {31'd0, out_valid}, 32'd1);
        chk("ovr_data", out_data, 32'h78563412);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_accept", {31'd0, out_valid}, 32'd0);

        // Sync on bit 13 realigns: new word starts there.
        sc = 32'hAA558001;
        send_range(sa, 0, 12, 0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, sc[W-1], 1'b1);
        chk("missync_err", {31'd0, sync_err}, 32'd1);
        send_range(sc, 1, NB, -1, 1'b1, 1'b0);
        chk("missync_valid", {31'd0, out_valid}, 32'd1);
        chk("missync_data", out_data, 32'hAA558001);

        // Missing sync on the next word start drops to HUNT.
        step(1'b0, 1'b1, 1'b0, sa[W-1], 1'b1);
        chk("nosync_err", {31'd0, sync_err}, 32'd1);
        send_range(sa, 1, NB, -1, 1'b1, 1'b0);
        chk("nosync_hunt", {31'd0, out_valid}, 32'd0);
        send_range(sb, 0, NB, 0, 1'b1, 1'b0);
        chk("nosync_recover", out_data, 32'h78563412);

        // Reset mid-word with valid and overrun set.
        send_range(sa, 0, NB, 0, 1'b0, 1'b0);
        send_range(sc, 0, NB, 0, 1'b0, 1'b0);
        send_range(sb, 0, 20, 0, 1'b0, 1'b0);
        chk("pre_rst_ovr", {31'd0, overrun}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        send_range(sc, 0, NB, 0, 1'b1, 1'b0);
        chk("post_rst_data", out_data, 32'hAA558001);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            step(1'b0, ($urandom_range(3) != 0), ($urandom_range(39) == 0),
                 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
